// File: rtl/cmd_seq.sv
// ---------------------------------------------------------------------------
// cmd_seq -- parametrised command sequencer.
//
// Consumes opcode/argument commands over a valid/ready handshake and uses
// them to program NCH channels. Each channel has an A_W-bit "a" register and
// a 1-bit "b" flag. Commands can also stall the stream for a number of
// cycles (WAIT), clear every channel (CLR), or park the sequencer for good
// (DONE, left only through rst). Illegal opcodes and out-of-range channel
// selects are consumed and raise a sticky err flag.
//
// Optional build macro: CMD_SEQ_CNT_EN adds a saturating 16-bit count of
// accepted commands on port cmd_cnt.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle (depends on state only)
//   cmd_op     in   3-bit opcode
//   cmd_ch     in   target channel
//   cmd_arg0   in   first argument
//   cmd_arg1   in   second argument
//   a          out  channel a registers, channel k at [k*A_W +: A_W]
//   b          out  channel b flags, bit k = channel k
//   busy       out  high while stalled in WAIT
//   done       out  high once DONE has been executed
//   err        out  sticky bad-command flag
//   cmd_cnt    out  accepted command count (CMD_SEQ_CNT_EN builds only)
// ---------------------------------------------------------------------------
module cmd_seq #(
  parameter int A_W   = 5,
  parameter int ARG_W = 8,
  parameter int NCH   = 4,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [ARG_W-1:0]     cmd_arg0,
  input  logic [ARG_W-1:0]     cmd_arg1,
  output logic [NCH*A_W-1:0]   a,
  output logic [NCH-1:0]       b,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef CMD_SEQ_CNT_EN
  ,
  output logic [15:0]          cmd_cnt
`endif
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_AAA  = 3'd1,
    OP_BBB  = 3'd2,
    OP_WAIT = 3'd3,
    OP_DONE = 3'd4,
    OP_CLR  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The AAA sum is formed one bit wider than the arguments; if a channel is
  // wider than that, the extra upper bits are simply zero.
  localparam int SUM_W = (A_W > ARG_W + 1) ? A_W : ARG_W + 1;

  state_t           state, state_next;
  logic [ARG_W-1:0] wait_cnt, wait_next;
  logic             accept;
  logic             ch_ok;
  logic [SUM_W-1:0] sum;

  assign accept = cmd_valid && cmd_ready;
  assign ch_ok  = (32'(cmd_ch) < NCH);
  assign sum    = SUM_W'(cmd_arg0) + SUM_W'(cmd_arg1);

  // State and wait-counter register. Reset discards any pending wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Next-state and handshake/status outputs. The outputs decode the state
  // only, so nothing on cmd_* reaches an output combinationally. In RUN
  // cmd_ready is 1, so cmd_valid alone means the command is accepted.
  // WAIT leaves on the cycle the counter reads 1, which makes cmd_ready low
  // for exactly arg0 cycles.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_RUN: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_WAIT && cmd_arg0 != '0) begin
            state_next = ST_WAIT;
            wait_next  = cmd_arg0;
          end else if (cmd_op == OP_DONE) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        busy      = 1'b1;
        wait_next = wait_cnt - 1'b1;
        if (wait_cnt == ARG_W'(1)) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_next = ST_RUN;
        wait_next  = '0;
      end
    endcase
  end

  // Channel registers and the sticky error flag. Bad commands are still
  // consumed; they only set err and leave every channel untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      err <= 1'b0;
    end else if (accept) begin
      case (cmd_op)
        OP_NOP, OP_WAIT, OP_DONE: begin
        end
        OP_AAA: begin
          if (ch_ok) begin
            for (int k = 0; k < NCH; k++) begin
              if (cmd_ch == CH_W'(k)) begin
                a[k*A_W +: A_W] <= sum[A_W-1:0];
              end
            end
          end else begin
            err <= 1'b1;
          end
        end
        OP_BBB: begin
          if (ch_ok) begin
            for (int k = 0; k < NCH; k++) begin
              if (cmd_ch == CH_W'(k)) begin
                b[k] <= cmd_arg0[0];
              end
            end
          end else begin
            err <= 1'b1;
          end
        end
        OP_CLR: begin
          a <= '0;
          b <= '0;
        end
        default: begin
          err <= 1'b1;
        end
      endcase
    end
  end

`ifdef CMD_SEQ_CNT_EN
  // Accepted-command counter; every accepted command counts, including NOP,
  // illegal opcodes and DONE. Holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt <= '0;
    end else if (accept && cmd_cnt != 16'hFFFF) begin
      cmd_cnt <= cmd_cnt + 16'd1;
    end
  end
`else
  // No command counter in this build.
`endif

endmodule
